// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//   Raster timing generator running in the pixel clock domain. Counts pixels
//   and lines and decodes registered sync, data-enable, pixel coordinates and
//   line/frame start strobes. Timing is held idle until the PLL lock flag has
//   been stable for LOCK_CYCLES cycles and drops back to idle on lock loss.
//   Default parameters give CEA-861 1080p60 (148.5 MHz pixel clock).
//
// Ports
//   refclk      in   pixel clock
//   rst         in   synchronous reset, active-high
//   pll_locked  in   PLL lock flag (asynchronous, synchronised here)
//   hsync       out  horizontal sync, active level HS_POL
//   vsync       out  vertical sync, active level VS_POL
//   de          out  data enable, high on active pixels
//   pix_x       out  active column (0 outside active video)
//   pix_y       out  active line   (0 outside active video)
//   line_start  out  1-cycle pulse on the first pixel of every line
//   frame_start out  1-cycle pulse on the first pixel of every frame
//   running     out  high while the raster is running
// -----------------------------------------------------------------------------
module video_timing_gen #(
    parameter int H_ACTIVE    = 1920,
    parameter int H_FP        = 88,
    parameter int H_SYNC      = 44,
    parameter int H_BP        = 148,
    parameter int V_ACTIVE    = 1080,
    parameter int V_FP        = 4,
    parameter int V_SYNC      = 5,
    parameter int V_BP        = 36,
    parameter bit HS_POL      = 1'b1,
    parameter bit VS_POL      = 1'b1,
    parameter int LOCK_CYCLES = 16
) (
    input  logic        refclk,
    input  logic        rst,
    input  logic        pll_locked,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] pix_x,
    output logic [10:0] pix_y,
    output logic        line_start,
    output logic        frame_start,
    output logic        running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    // Lock counter only needs to reach LOCK_CYCLES-1.
    localparam int            LW        = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);

    typedef enum logic {
        WAIT_LOCK = 1'b0,
        RUN       = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [LW-1:0] lock_cnt, lock_nxt;
    logic [11:0]   h_cnt, h_nxt;
    logic [10:0]   v_cnt, v_nxt;
    logic          lock_meta, lock_s;

    // Two-flop synchroniser for the asynchronous lock flag.
    always_ff @(posedge refclk) begin
        // NOTE: every sequential assignment is non-blocking so all flops
        // update together from pre-edge values, matching the hardware.
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    // State and counter register.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state    <= WAIT_LOCK;
            lock_cnt <= '0;
            h_cnt    <= '0;
            v_cnt    <= '0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_nxt;
            h_cnt    <= h_nxt;
            v_cnt    <= v_nxt;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no
        // latch is inferred.
        state_nxt = state;
        lock_nxt  = lock_cnt;
        h_nxt     = h_cnt;
        v_nxt     = v_cnt;
        unique case (state)
            WAIT_LOCK: begin
                h_nxt = '0;
                v_nxt = '0;
                if (!lock_s) begin
                    lock_nxt = '0;
                end else if (lock_cnt == LOCK_LAST) begin
                    state_nxt = RUN;
                    lock_nxt  = '0;
                end else begin
                    lock_nxt = lock_cnt + 1'b1;
                end
            end
            RUN: begin
                lock_nxt = '0;
                if (!lock_s) begin
                    // Abandon the frame immediately; restart from h=v=0.
                    state_nxt = WAIT_LOCK;
                    h_nxt     = '0;
                    v_nxt     = '0;
                end else if (h_cnt == H_LAST) begin
                    h_nxt = '0;
                    v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_nxt = h_cnt + 1'b1;
                end
            end
            default: state_nxt = WAIT_LOCK;
        endcase
    end

    // Decode. Outputs are only live while running with lock still present;
    // on the cycle lock loss is seen they are forced idle together with the
    // state change.
    logic run_ok, h_act, v_act, hs_on, vs_on;

    always_comb begin
        run_ok = (state == RUN) && lock_s;
        h_act  = (h_cnt < H_ACT);
        v_act  = (v_cnt < V_ACT);
        hs_on  = (h_cnt >= HS_START) && (h_cnt < HS_END);
        vs_on  = (v_cnt >= VS_START) && (v_cnt < VS_END);
    end

    always_ff @(posedge refclk) begin
        if (rst || !run_ok) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            running     <= 1'b0;
        end else begin
            hsync       <= hs_on ? HS_POL : ~HS_POL;
            vsync       <= vs_on ? VS_POL : ~VS_POL;
            de          <= h_act && v_act;
            pix_x       <= (h_act && v_act) ? h_cnt : '0;
            pix_y       <= (h_act && v_act) ? v_cnt : '0;
            line_start  <= (h_cnt == '0);
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            running     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_video_timing_gen
//   Drives two instances from one reset/lock stimulus: the default 1080p60
//   timing and a tiny raster (H 8/2/2/2, V 4/1/1/1, active-low syncs).
//   A reference model computes each instance's expected outputs every cycle
//   from the raster position; a monitor pops and compares them. Directed
//   measurements cover lock latency, line/frame geometry and lock loss.
// -----------------------------------------------------------------------------
module tb_video_timing_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] x;
        logic [10:0] y;
        logic        ls;
        logic        fs;
        logic        run;
    } vout_t;

    localparam int LOCKN = 16;

    // Index 0: default timing, index 1: small timing.
    int ha  [2] = '{1920, 8};
    int hf  [2] = '{88, 2};
    int hsw [2] = '{44, 2};
    int hb  [2] = '{148, 2};
    int va  [2] = '{1080, 4};
    int vf  [2] = '{4, 1};
    int vsw [2] = '{5, 1};
    int vb  [2] = '{36, 1};
    bit hpol[2] = '{1'b1, 1'b0};
    bit vpol[2] = '{1'b1, 1'b0};

    logic refclk = 1'b0;
    always #5 refclk = ~refclk;

    logic rst;
    logic pll_locked;

    logic        d_hs, d_vs, d_de, d_ls, d_fs, d_run;
    logic [11:0] d_x;
    logic [10:0] d_y;
    logic        s_hs, s_vs, s_de, s_ls, s_fs, s_run;
    logic [11:0] s_x;
    logic [10:0] s_y;

    video_timing_gen dut_d (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked),
        .hsync(d_hs), .vsync(d_vs), .de(d_de), .pix_x(d_x), .pix_y(d_y),
        .line_start(d_ls), .frame_start(d_fs), .running(d_run)
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_CYCLES(16)
    ) dut_s (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked),
        .hsync(s_hs), .vsync(s_vs), .de(s_de), .pix_x(s_x), .pix_y(s_y),
        .line_start(s_ls), .frame_start(s_fs), .running(s_run)
    );

    vout_t act_d, act_s;
    assign act_d = {d_hs, d_vs, d_de, d_x, d_y, d_ls, d_fs, d_run};
    assign act_s = {s_hs, s_vs, s_de, s_x, s_y, s_ls, s_fs, s_run};

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- model
    function automatic int h_total(int d);
        return ha[d] + hf[d] + hsw[d] + hb[d];
    endfunction

    function automatic int frame_len(int d);
        return h_total(d) * (va[d] + vf[d] + vsw[d] + vb[d]);
    endfunction

    function automatic vout_t idle_out(int d);
        vout_t o;
        o     = '0;
        o.hs  = ~hpol[d];
        o.vs  = ~vpol[d];
        return o;
    endfunction

    // Expected outputs for raster position p (pixels since frame start).
    function automatic vout_t decode(int d, int p);
        vout_t o;
        int h, v;
        h     = p % h_total(d);
        v     = p / h_total(d);
        o.de  = (h < ha[d]) && (v < va[d]);
        o.x   = o.de ? 12'(h) : 12'd0;
        o.y   = o.de ? 11'(v) : 11'd0;
        o.hs  = (h >= ha[d] + hf[d] && h < ha[d] + hf[d] + hsw[d]) ? hpol[d] : ~hpol[d];
        o.vs  = (v >= va[d] + vf[d] && v < va[d] + vf[d] + vsw[d]) ? vpol[d] : ~vpol[d];
        o.ls  = (h == 0);
        o.fs  = (p == 0);
        o.run = 1'b1;
        return o;
    endfunction

    vout_t q_d[$];
    vout_t q_s[$];

    // Model: lock flag seen two edges late; raster runs after LOCKN
    // consecutive locked samples and stops on the first unlocked one.
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_run[2];
    int m_streak[2];
    int m_pos[2];

    initial begin
        vout_t e;
        for (int d = 0; d < 2; d++) begin
            m_s1[d] = 0; m_s2[d] = 0; m_run[d] = 0; m_streak[d] = 0; m_pos[d] = 0;
        end
        forever begin
            @(posedge refclk);
            for (int d = 0; d < 2; d++) begin
                e = idle_out(d);
                if (!rst && m_run[d] && m_s2[d]) e = decode(d, m_pos[d]);
                if (d == 0) q_d.push_back(e);
                else        q_s.push_back(e);
                if (rst) begin
                    m_s1[d] = 0; m_s2[d] = 0; m_run[d] = 0; m_streak[d] = 0; m_pos[d] = 0;
                end else begin
                    if (m_run[d]) begin
                        if (m_s2[d]) m_pos[d] = (m_pos[d] + 1) % frame_len(d);
                        else begin m_run[d] = 0; m_pos[d] = 0; m_streak[d] = 0; end
                    end else if (m_s2[d]) begin
                        m_streak[d]++;
                        if (m_streak[d] == LOCKN) begin m_run[d] = 1; m_pos[d] = 0; m_streak[d] = 0; end
                    end else begin
                        m_streak[d] = 0;
                    end
                    m_s2[d] = m_s1[d];
                    m_s1[d] = pll_locked;
                end
            end
        end
    end

    // Monitor: compares each registered output set against the model.
    initial begin
        vout_t e;
        forever begin
            @(negedge refclk);
            if (q_d.size() > 0) begin
                e = q_d.pop_front();
                check("sb_default", {3'b000, act_d}, {3'b000, e});
            end
            if (q_s.size() > 0) begin
                e = q_s.pop_front();
                check("sb_small", {3'b000, act_s}, {3'b000, e});
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic cycles(input int n);
        repeat (n) @(negedge refclk);
    endtask

    // Counts negedges until dut_d reports running (bounded).
    task automatic wait_run(output int cnt);
        cnt = 0;
        do begin @(negedge refclk); cnt++; end while (!d_run && cnt < 100);
    endtask

    initial begin
        int cnt, de_n, hs_n, hs_first, ls_n, vs_n, mx, my;
        rst        = 1'b1;
        pll_locked = 1'b1;
        cycles(4);
        check("rst_running", d_run, 0);
        check("rst_de", d_de, 0);
        check("rst_hsync_d", d_hs, 0);
        check("rst_hsync_s", s_hs, 1);
        check("rst_vsync_s", s_vs, 1);

        // Lock latency: 2 sync + 16 lock + 1 output.
        rst = 1'b0;
        wait_run(cnt);
        check("lock_latency", cnt, 19);
        check("first_fs", d_fs, 1);
        check("first_de", d_de, 1);
        check("first_pix_x", d_x, 0);
        check("first_pix_y", d_y, 0);
        check("first_fs_small", s_fs, 1);

        // One default line, starting from the h=0 output cycle.
        de_n = 0; hs_n = 0; hs_first = -1; ls_n = 0;
        for (int i = 0; i < 2200; i++) begin
            if (i > 0) @(negedge refclk);
            de_n += int'(d_de);
            if (d_hs) begin hs_n++; if (hs_first < 0) hs_first = i; end
            if (i > 0) ls_n += int'(d_ls);
        end
        check("line_de_count", de_n, 1920);
        check("line_hsync_count", hs_n, 44);
        check("line_hsync_first", hs_first, 2008);
        check("line_ls_inside", ls_n, 0);
        @(negedge refclk);
        check("line_period", d_ls, 1);
        check("line1_pix_y", d_y, 1);

        // Three small frames.
        cnt = 0;
        while (!s_fs && cnt < 200) begin @(negedge refclk); cnt++; end
        check("small_fs_found", s_fs, 1);
        for (int f = 0; f < 3; f++) begin
            de_n = 0; hs_n = 0; vs_n = 0; mx = 0; my = 0;
            for (int i = 0; i < 98; i++) begin
                if (i > 0) @(negedge refclk);
                de_n += int'(s_de);
                hs_n += int'(!s_hs);
                vs_n += int'(!s_vs);
                if (s_de && int'(s_x) > mx) mx = int'(s_x);
                if (s_de && int'(s_y) > my) my = int'(s_y);
            end
            check("small_de_count", de_n, 32);
            check("small_hsync_low", hs_n, 14);
            check("small_vsync_low", vs_n, 14);
            check("small_last_x", mx, 7);
            check("small_last_y", my, 3);
            @(negedge refclk);
            check("small_frame_period", s_fs, 1);
        end

        cycles(15000);

        // Lock glitch: counter must restart after the single low cycle.
        pll_locked = 1'b0;
        cycles(6);
        check("unlocked_running", d_run, 0);
        pll_locked = 1'b1;
        cycles(10);
        pll_locked = 1'b0;
        cycles(1);
        pll_locked = 1'b1;
        wait_run(cnt);
        check("glitch_relock", cnt, 19);

        // Lock loss mid-line at pix_x=500.
        cnt = 0;
        while (!(d_de && d_x == 12'd500 && d_y != 11'd0) && cnt < 5000) begin
            @(negedge refclk); cnt++;
        end
        check("found_x500", d_x, 500);
        pll_locked = 1'b0;
        cnt = 0;
        do begin @(negedge refclk); cnt++; end while (d_run && cnt < 10);
        check("lockloss_latency", cnt, 3);
        check("lockloss_de", d_de, 0);
        check("lockloss_hsync", d_hs, 0);
        check("lockloss_vsync", d_vs, 0);
        pll_locked = 1'b1;
        wait_run(cnt);
        check("relock_latency", cnt, 19);
        check("relock_fs", d_fs, 1);

        // Reset pulse mid-frame.
        cycles(500);
        rst = 1'b1;
        @(negedge refclk);
        check("midrst_running", d_run, 0);
        check("midrst_de", d_de, 0);
        check("midrst_hsync_s", s_hs, 1);
        rst = 1'b0;
        wait_run(cnt);
        check("midrst_relock", cnt, 19);

        // Random lock drops and reset pulses, checked by the scoreboard.
        for (int k = 0; k < 40; k++) begin
            cycles($urandom_range(30, 600));
            case ($urandom_range(0, 3))
                0: begin
                    rst = 1'b1;
                    cycles($urandom_range(1, 3));
                    rst = 1'b0;
                end
                1, 2: begin
                    pll_locked = 1'b0;
                    cycles($urandom_range(1, 5));
                    pll_locked = 1'b1;
                end
                default: ;
            endcase
        end

        cycles(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
